// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbitrated binary-to-BCD converter (double-dabble, WIDTH shift cycles, result held until out_ready).
// Define BCD_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); no grants are issued while busy.
module bcd_conv_arbiter #(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*DIGITS-1:0]     out_bcd,
  output logic [IDW-1:0]          out_id,
  output logic                    busy
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  bin_q, bin_nxt;
  logic [BW-1:0]     bcd_q, bcd_adj, bcd_nxt;
  logic [CW-1:0]     cnt_q;
  logic [IDW-1:0]    id_q, grant_id;
  logic [NREQ-1:0]   grant;
  logic              found;
  logic              transfer;
  int                idx;

`ifndef BCD_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]    last_q;
`endif

  // Winner search: from last+1 with wrap, or from index 0 in fixed-priority mode.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef BCD_ARB_FIXED_PRIO_EN
      idx = k;
`else
      idx = (int'(last_q) + 1 + k) % NREQ;
`endif
      if (!found && req_valid[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx[IDW-1:0];
      end
    end
  end

  assign req_ready = (state == IDLE && !reset) ? grant : '0;
  assign transfer  = |req_ready;

  // Add-3 correction applies to the pre-shift digits; the shift consumes the corrected value.
  always_comb begin
    bcd_adj = bcd_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5)
        bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
    end
    {bcd_nxt, bin_nxt} = {bcd_adj, bin_q} << 1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (transfer) state_nxt = SHIFT;
      SHIFT:   if (cnt_q == CW'(1)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      id_q  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (transfer) begin
          bin_q <= req_data[int'(grant_id)*WIDTH +: WIDTH];
          bcd_q <= '0;
          cnt_q <= CW'(WIDTH);
          id_q  <= grant_id;
        end
        SHIFT: begin
          bin_q <= bin_nxt;
          bcd_q <= bcd_nxt;
          cnt_q <= cnt_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

`ifndef BCD_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk) begin
    if (reset)
      last_q <= IDW'(NREQ - 1);
    else if (state == DONE && out_ready)
      last_q <= id_q;
  end
`endif

  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_bcd   = bcd_q;
  assign out_id    = id_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Randomized self-checking bench for bcd_conv_arbiter against an arithmetic BCD / arbitration model.
module tb_bcd_conv_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_bcd;
  logic [1:0]  out_id;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int last_m   = 3;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_conv_arbiter #(.NREQ(4), .WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_bcd(out_bcd), .out_id(out_id), .busy(busy)
  );

  function automatic logic [11:0] bcd_ref(int v);
    logic [11:0] r;
    r[3:0]  = 4'(v % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[11:8] = 4'((v / 100) % 10);
    return r;
  endfunction

  function automatic int arb_ref(logic [3:0] vld, int last);
`ifdef BCD_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) if (vld[i]) return i;
`else
    for (int k = 1; k <= 4; k++) if (vld[(last + k) % 4]) return (last + k) % 4;
`endif
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns granted index (-1 on timeout) and the raw grant vector; ends just after the transfer edge.
  task automatic wait_grant(output int gid, output logic [3:0] rr, output int gcyc);
    gid = -1; rr = '0; gcyc = -1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (req_ready != 4'b0) begin
        rr = req_ready;
        gcyc = cyc;
        for (int i = 0; i < 4; i++) if (req_ready[i]) gid = i;
        step();
        return;
      end
      step();
    end
  endtask

  // Counts edges after the transfer edge until out_valid (-1 on timeout).
  task automatic wait_done(output int lat);
    lat = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) return;
      step();
      lat++;
    end
    lat = -1;
  endtask

  task automatic do_conv(input int id, input int v, output int gid, output int lat,
                         output logic [11:0] bcd, output int oid);
    logic [3:0] rr;
    int gc;
    req_valid = 4'b0;
    req_valid[id] = 1'b1;
    req_data[id*8 +: 8] = 8'(v);
    wait_grant(gid, rr, gc);
    req_valid = 4'b0;
    wait_done(lat);
    bcd = out_bcd;
    oid = int'(out_id);
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 4'hF; out_ready = 1'b1;
    step(); step();
    checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_bcd !== 12'h000) begin failures++; $display("FAIL reset_out_bcd got=%h exp=000", out_bcd); end
    checks++; if (out_id !== 2'd0) begin failures++; $display("FAIL reset_out_id got=%0d exp=0", out_id); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset = 1'b0; req_valid = 4'b0; last_m = 3;
    step();
  endtask

  task automatic test_zero();
    int gid, gc, lat;
    logic [3:0] rr;
    req_data = 32'h0; req_valid = 4'b0001;
    wait_grant(gid, rr, gc);
    req_valid = 4'b0;
    checks++; if (rr !== 4'b0001) begin failures++; $display("FAIL zero_grant got=%b exp=0001", rr); end
    #1;
    checks++; if (req_ready !== 4'b0 || busy !== 1'b1) begin failures++; $display("FAIL zero_shift_state rdy=%b busy=%b exp rdy=0000 busy=1", req_ready, busy); end
    wait_done(lat);
    checks++; if (lat !== 8) begin failures++; $display("FAIL zero_latency got=%0d exp=8", lat); end
    checks++; if (out_bcd !== 12'h000 || out_id !== 2'd0) begin failures++; $display("FAIL zero_result got=%h/%0d exp=000/0", out_bcd, out_id); end
    step();
    last_m = 0;
  endtask

  task automatic test_single();
    int gid, lat, oid;
    logic [11:0] bcd;
    do_conv(2, 255, gid, lat, bcd, oid);
    checks++; if (gid !== 2) begin failures++; $display("FAIL single_grant got=%0d exp=2", gid); end
    checks++; if (lat !== 8) begin failures++; $display("FAIL single_latency got=%0d exp=8", lat); end
    checks++; if (bcd !== 12'h255 || oid !== 2) begin failures++; $display("FAIL single_result got=%h/%0d exp=255/2", bcd, oid); end
    last_m = 2;
  endtask

  task automatic test_sweep();
    int gid, lat, oid, id, v;
    logic [11:0] bcd;
    for (int n = 0; n < 256 + 40; n++) begin
      id = (n < 256) ? 0 : int'($urandom_range(0, 3));
      v  = (n < 256) ? n : int'($urandom_range(0, 255));
      do_conv(id, v, gid, lat, bcd, oid);
      checks++;
      if (gid !== id || lat !== 8 || bcd !== bcd_ref(v) || oid !== id) begin
        failures++;
        $display("FAIL sweep v=%0d got grant=%0d lat=%0d bcd=%h id=%0d exp grant=%0d lat=8 bcd=%h id=%0d",
                 v, gid, lat, bcd, oid, id, bcd_ref(v), id);
      end
      last_m = id;
    end
  endtask

  task automatic test_round_robin();
    int gid, gc, prev_gc, lat, exp;
    logic [3:0] rr;
    req_data = {8'd40, 8'd30, 8'd20, 8'd10};
    req_valid = 4'hF;
    prev_gc = -1;
    for (int n = 0; n < 5; n++) begin
      exp = arb_ref(4'hF, last_m);
      wait_grant(gid, rr, gc);
      checks++; if (gid !== exp || !$onehot(rr)) begin failures++; $display("FAIL rr_grant n=%0d got=%b exp_idx=%0d", n, rr, exp); end
      if (n > 0) begin
        checks++; if (gc - prev_gc !== 10) begin failures++; $display("FAIL rr_spacing n=%0d got=%0d exp=10", n, gc - prev_gc); end
      end
      prev_gc = gc;
      wait_done(lat);
      checks++;
      if (out_bcd !== bcd_ref((exp + 1) * 10) || int'(out_id) !== exp) begin
        failures++; $display("FAIL rr_result n=%0d got=%h/%0d exp=%h/%0d", n, out_bcd, out_id, bcd_ref((exp + 1) * 10), exp);
      end
      step();
      last_m = exp;
    end
    req_valid = 4'b0;
    step();
  endtask

  task automatic test_backpressure();
    int gid, gc, lat, v;
    logic [3:0] rr;
    v = int'($urandom_range(0, 255));
    out_ready = 1'b0;
    req_data[15:8] = 8'(v);
    req_valid = 4'b0010;
    wait_grant(gid, rr, gc);
    req_valid = 4'b1000;
    req_data[31:24] = 8'd99;
    wait_done(lat);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_bcd !== bcd_ref(v) || out_id !== 2'd1 || req_ready !== 4'b0) begin
        failures++;
        $display("FAIL hold c=%0d got vld=%b bcd=%h id=%0d rdy=%b exp vld=1 bcd=%h id=1 rdy=0000",
                 c, out_valid, out_bcd, out_id, req_ready, bcd_ref(v));
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL handshake_no_grant got=%b exp=0000", req_ready); end
    step();
    last_m = 1;
    checks++; if (out_valid !== 1'b0 || req_ready !== 4'b1000) begin failures++; $display("FAIL release got vld=%b rdy=%b exp vld=0 rdy=1000", out_valid, req_ready); end
    wait_grant(gid, rr, gc);
    req_valid = 4'b0;
    wait_done(lat);
    checks++; if (gid !== 3 || out_bcd !== 12'h099) begin failures++; $display("FAIL post_release got=%0d/%h exp=3/099", gid, out_bcd); end
    step();
    last_m = 3;
  endtask

  task automatic test_reset_mid();
    int gid, gc, lat;
    logic [3:0] rr;
    req_data[31:24] = 8'd77;
    req_valid = 4'b1000;
    wait_grant(gid, rr, gc);
    step(); step(); step();
    reset = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || out_bcd !== 12'h0 || out_id !== 2'd0 || busy !== 1'b0 || req_ready !== 4'b0) begin
      failures++;
      $display("FAIL mid_reset got vld=%b bcd=%h id=%0d busy=%b rdy=%b exp all 0", out_valid, out_bcd, out_id, busy, req_ready);
    end
    reset = 1'b0;
    last_m = 3;
    req_data[7:0] = 8'd123;
    req_valid = 4'b1001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL after_reset_prio got=%b exp=0001", req_ready); end
    wait_grant(gid, rr, gc);
    req_valid = 4'b0;
    wait_done(lat);
    checks++; if (gid !== 0 || out_bcd !== 12'h123 || lat !== 8) begin failures++; $display("FAIL after_reset_conv got=%0d/%h/%0d exp=0/123/8", gid, out_bcd, lat); end
    step();
    last_m = 0;
  endtask

  task automatic test_two_reqs();
    int gid, gc, lat, exp, v1, v3;
    logic [3:0] rr;
    v1 = int'($urandom_range(0, 255));
    v3 = int'($urandom_range(0, 255));
    req_data[15:8]  = 8'(v1);
    req_data[31:24] = 8'(v3);
    req_valid = 4'b1010;
    for (int n = 0; n < 3; n++) begin
      exp = arb_ref(4'b1010, last_m);
      wait_grant(gid, rr, gc);
      wait_done(lat);
      checks++;
      if (gid !== exp || out_bcd !== bcd_ref(exp == 1 ? v1 : v3) || int'(out_id) !== exp) begin
        failures++;
        $display("FAIL two_reqs n=%0d got=%0d/%h exp=%0d/%h", n, gid, out_bcd, exp, bcd_ref(exp == 1 ? v1 : v3));
      end
      step();
      last_m = exp;
    end
    req_valid = 4'b0;
    step();
  endtask

  initial begin
    reset = 1'b1; req_valid = 4'b0; req_data = 32'h0; out_ready = 1'b1;
    test_reset();
    test_zero();
    test_single();
    test_sweep();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_two_reqs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_conv_arbiter.md
# bcd_conv_arbiter

Shared binary-to-BCD conversion engine with a request arbiter. Up to NREQ requesters present binary values. The block grants one at a time (round-robin) and runs a shift-add-3 (double-dabble) sequence on the granted value for WIDTH cycles. It returns the packed BCD result tagged with the requester index over a valid/ready output port. It sits between the counter/measurement blocks and the display drivers, so one converter serves several display channels.

## Interface
- NREQ, 4, number of requesters (≥2)
- WIDTH, 8, binary input width (≥2)
- DIGITS, 3, BCD digits in result; must satisfy 10^DIGITS > 2^WIDTH−1
- IDW, $clog2(NREQ), requester-index width (derived localparam)
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high; clears all state
- req_valid  in  NREQ  requester i has a value pending
- req_data  in  NREQ*WIDTH  requester i value at [i*WIDTH +: WIDTH]
- req_ready  out  NREQ  one-hot grant; transfer on req_valid[i] & req_ready[i]
- out_valid  out  1  result available
- out_ready  in  1  sink accepts result
- out_bcd  out  4*DIGITS  packed BCD, digit k at [4k+3:4k], k=0 = ones
- out_id  out  IDW  index of requester the result belongs to
- busy  out  1  high in SHIFT or DONE

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset → IDLE.
- IDLE:
  - req_ready is a combinational one-hot of the winner among req_valid, searching from (last+1) mod NREQ upward with wrap.
  - All req_ready are 0 when no req_valid is set.
  - On transfer: capture req_data slice into the shift register, capture index into the id register, clear the BCD accumulator, load counter = WIDTH, and go to SHIFT.
- SHIFT, each cycle:
  - Each BCD digit ≥5 gets +3 (4-bit wrap-free, since digit ≤9).
  - The corrected {bcd, bin} is then shifted left 1 bit.
  - counter decrements. After the shift that takes counter from 1 to 0, go to DONE.
  - Correction and shift are one combinational step per cycle. The correction is applied to the pre-shift value, never overwritten by the shift assignment.
- DONE:
  - out_valid = 1. out_bcd and out_id are stable.
  - On out_ready: last ← out_id, go to IDLE.
- req_ready = 0 in SHIFT and DONE. Requests arriving then wait; requesters hold req_valid and req_data until granted.
- Requester dropping req_valid before grant: legal, simply not selected.
- Reset at any point, including mid-SHIFT or in DONE: the conversion is discarded. out_valid, out_bcd, out_id and busy all go to 0, and last = NREQ−1 so requester 0 has first priority.

## Timing
- Reset values: out_valid 0, out_bcd 0, out_id 0, busy 0, req_ready 0 (in reset cycle, forced).
- Latency: grant accepted at edge E0; out_valid rises after edge E0+WIDTH.
- Minimum occupancy per conversion: WIDTH+2 cycles (1 IDLE grant + WIDTH SHIFT + 1 DONE with out_ready=1).
- out_valid and out_bcd hold indefinitely under out_ready=0.
- No grant is issued in the same cycle as the DONE handshake. The next grant happens in the following IDLE cycle.

## Configuration
- BCD_ARB_FIXED_PRIO_EN defined: fixed priority, lowest asserted index always wins. The `last` pointer is not implemented.
- Undefined (default): round-robin as described above.

## Test plan
- Reset, then req_valid=4'b0001 with data 0 → req_ready=4'b0001 for one cycle; 8 cycles later out_valid=1, out_bcd=12'h000, out_id=0.
- Single requester 2, data 255 → out_bcd=12'h255, out_id=2, out_valid exactly 8 edges after grant. Sweep 0..255 through requester 0 against a reference model.
- All four req_valid held continuously, data 10,20,30,40 → grants in order 0,1,2,3,0 every 10 cycles; results 12'h010, 12'h020, 12'h030, 12'h040.
- out_ready low for 5 cycles in DONE → out_valid, out_bcd and out_id stable; req_ready=0 throughout. Release → IDLE, then the next grant.
- reset asserted 3 cycles into SHIFT with req 3 active → outputs 0 next cycle. With reqs 0 and 3 valid after release, the first grant goes to 0.
- With BCD_ARB_FIXED_PRIO_EN, reqs 1 and 3 continuously valid → every grant goes to 1. Without the macro, grants alternate 1,3,1.
